// File: rtl/micro_mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : micro_mult_pkg
//  Brief    : Shared types, constants and helpers for the micro multiplier.
//  Revision : 1.0 - initial release
// ============================================================================
package micro_mult_pkg;

    // Control states of the sequential multiplier.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mm_state_t;

    // Default operand width in bits.
    localparam int MM_WIDTH = 8;

    // Width of the iteration counter needed to count WIDTH steps.
    function automatic int mm_cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/micro_mult_shift_add.sv
`default_nettype none
// ============================================================================
//  Module   : micro_mult_shift_add
//  Brief    : Shift-and-add datapath: accumulator, shifted multiplicand and
//             right-shifting multiplier, advanced one bit per step.
//  Revision : 1.0 - initial release
// ============================================================================
module micro_mult_shift_add
    import micro_mult_pkg::*;
#(
    parameter int WIDTH = MM_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic [2*WIDTH-1:0]   acc_next_o
);

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_d;

    // Accumulator value after the current step; the controller captures this
    // on the last step so the final partial product is included.
    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end
    end

    assign acc_next_o = acc_d;

    // Load operands on an accepted start, otherwise consume one multiplier bit per step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (load_i) begin
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            mplier_q <= b_i;
        end else if (step_i) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/micro_mult_core.sv
`default_nettype none
// ============================================================================
//  Module   : micro_mult_core
//  Brief    : Sequential unsigned shift-and-add multiplier with a byte-wide
//             product readout port for an 8-bit pin wrapper.
//  Revision : 1.0 - initial release
// ============================================================================
module micro_mult_core
    import micro_mult_pkg::*;
#(
    parameter int WIDTH = MM_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              ena,
    input  logic                              start,
    input  logic [WIDTH-1:0]                  a,
    input  logic [WIDTH-1:0]                  b,
    input  logic [$clog2(2*WIDTH/8)-1:0]      byte_sel,
    output logic                              busy,
    output logic                              done,
    output logic [2*WIDTH-1:0]                product,
    output logic [7:0]                        out_byte
);

    localparam int                CNT_W    = mm_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
    localparam int                NBYTES   = 2 * WIDTH / 8;
    localparam logic [31:0]       NBYTES_U = 32'(NBYTES);

    mm_state_t          state_q;
    mm_state_t          state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [2*WIDTH-1:0] product_q;
    logic [2*WIDTH-1:0] product_d;
    logic               load;
    logic               step;
    logic [2*WIDTH-1:0] acc_next;
    logic [31:0]        sel_ext;

    micro_mult_shift_add #(
        .WIDTH      (WIDTH)
    ) u_datapath (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load),
        .step_i     (step),
        .a_i        (a),
        .b_i        (b),
        .acc_next_o (acc_next)
    );

    // Controller state, step counter and result register; all frozen by ena=0
    // through the next-state logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // Next-state and datapath enables; nothing advances while ena is low.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        load      = 1'b0;
        step      = 1'b0;
        if (ena) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        load    = 1'b1;
                        cnt_d   = '0;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    step  = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        product_d = acc_next;
                        state_d   = DONE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Status flags decode directly from the registered state.
    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    assign product = product_q;
    assign sel_ext = 32'(byte_sel);

    // Byte readout mux; out-of-range selects wrap modulo the byte count.
    always_comb begin
        out_byte = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if ((sel_ext % NBYTES_U) == 32'(i)) begin
                out_byte = product_q[8*i +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_micro_mult_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_micro_mult_core
//  Brief    : Self-checking bench for micro_mult_core; reference is plain
//             integer multiplication plus the documented cycle timing.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_micro_mult_core;

    localparam int W = 8;

    logic          clk;
    logic          rst_n;
    logic          ena;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [0:0]    byte_sel;
    logic          busy;
    logic          done;
    logic [2*W-1:0] product;
    logic [7:0]    out_byte;

    int vectors;
    int miscompares;

    micro_mult_core #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .start    (start),
        .a        (a),
        .b        (b),
        .byte_sel (byte_sel),
        .busy     (busy),
        .done     (done),
        .product  (product),
        .out_byte (out_byte)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One multiply through the port protocol; optional mid-run start pulse
    // and optional three-cycle ena gap starting gap_at edges after accept.
    task automatic run_mult(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                            input bit mid_start, input int gap_at);
        int             edges;
        int             busy_cnt;
        int             exp_lat;
        logic [2*W-1:0] expv;
        expv     = 16'(av) * 16'(bv);
        exp_lat  = W + ((gap_at > 0) ? 3 : 0);
        edges    = 0;
        busy_cnt = 0;
        a = av; b = bv; start = 1'b1; ena = 1'b1;
        tick();
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        while (done !== 1'b1 && edges < 100) begin
            if (busy === 1'b1) busy_cnt++;
            start = (mid_start && edges == 3);
            if (mid_start && edges == 3) begin
                a = 8'hFF; b = 8'hFF;
            end
            ena = !(gap_at > 0 && edges >= gap_at && edges < gap_at + 3);
            tick();
            edges++;
        end
        start = 1'b0;
        ena   = 1'b1;
        check({tag, " latency"}, 32'(edges), 32'(exp_lat));
        check({tag, " busy cycles"}, 32'(busy_cnt), 32'(exp_lat));
        check({tag, " busy at done"}, 32'(busy), 32'(0));
        check({tag, " product"}, 32'(product), 32'(expv));
        byte_sel = 1'b0; #1;
        check({tag, " byte0"}, 32'(out_byte), 32'(expv[7:0]));
        byte_sel = 1'b1; #1;
        check({tag, " byte1"}, 32'(out_byte), 32'(expv[15:8]));
        tick();
        check({tag, " done pulse width"}, 32'(done), 32'(0));
        check({tag, " product held"}, 32'(product), 32'(expv));
    endtask

    initial begin
        int            n;
        int            dones;
        int            last_done;
        logic [W-1:0]  ra;
        logic [W-1:0]  rb;
        vectors = 0; miscompares = 0;
        rst_n = 1'b0; ena = 1'b0; start = 1'b0; a = '0; b = '0; byte_sel = 1'b0;

        // Reset state
        tick(); tick();
        check("reset busy", 32'(busy), 32'(0));
        check("reset done", 32'(done), 32'(0));
        check("reset product", 32'(product), 32'(0));
        check("reset out_byte", 32'(out_byte), 32'(0));
        rst_n = 1'b1;
        tick();

        // Directed products
        run_mult("13x11", 8'd13, 8'd11, 1'b0, 0);
        run_mult("255x255", 8'd255, 8'd255, 1'b0, 0);
        run_mult("0x200", 8'd0, 8'd200, 1'b0, 0);

        // Start re-asserted during RUN is ignored
        run_mult("midstart", 8'd21, 8'd6, 1'b1, 0);

        // ena gap of three cycles mid-run
        run_mult("enagap", 8'd7, 8'd9, 1'b0, 4);

        // Reset during RUN: abort, clear, no done
        a = 8'h55; b = 8'h77; start = 1'b1; ena = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        #1;
        check("abort busy", 32'(busy), 32'(0));
        check("abort product", 32'(product), 32'(0));
        tick();
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1) dones++;
            tick();
        end
        check("abort no done", 32'(dones), 32'(0));
        run_mult("2x3", 8'd2, 8'd3, 1'b0, 0);

        // Randomized operands against integer multiplication
        for (int k = 0; k < 6; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_mult("random", ra, rb, 1'b0, 0);
        end

        // Start held high: back-to-back results every W+2 cycles
        a = 8'd3; b = 8'd5; start = 1'b1; ena = 1'b1;
        n = 0; dones = 0; last_done = 0;
        while (dones < 3 && n < 200) begin
            tick();
            n++;
            if (done === 1'b1) begin
                check("b2b product", 32'(product), 32'(15));
                if (dones > 0) check("b2b period", 32'(n - last_done), 32'(W + 2));
                last_done = n;
                dones++;
            end
        end
        check("b2b count", 32'(dones), 32'(3));
        start = 1'b0;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
